seven_seg_scan_ctrl: RTL

Time-multiplexed scan controller that shares one seven-segment decoder between NUM_DIGITS common-cathode digits. It holds a displayed value, presents one 4-bit nibble at a time to the decoder input, and drives one-hot digit enables. Inter-digit blanking suppresses ghosting. A shadow buffer with a valid/ready handshake lets new values be loaded without tearing; updates take effect only at frame boundaries. It sits between the datapath result register and the shared SEVEN_SEGMENT decoder.

---
 rtl/seven_seg_scan_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - multiplexed seven-segment digit scan controller with frame-synchronous shadow load
// Optional build macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN (suppresses leading-zero digits above digit 0).
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    i_CLK,
  input  logic                    i_RST_N,
  input  logic [4*NUM_DIGITS-1:0] i_DATA_IN,
  input  logic                    i_VALID,
  output logic                    o_READY,
  input  logic                    i_ENABLE,
  output logic [3:0]              o_NIBBLE,
  output logic [NUM_DIGITS-1:0]   o_DIGIT_EN,
  output logic                    o_FRAME_TICK
);

  localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int DW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DW-1:0]           digit_q, digit_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                    shadow_full_q, shadow_full_d;
  logic [3:0]              nibble_q, nibble_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                    frame_tick_q, frame_tick_d;

  logic                    boundary;
  logic                    accept;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [NUM_DIGITS-1:0]   lit;
  logic [3:0]              nibble_sel;

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q       <= ST_BLANK;
      cnt_q         <= '0;
      digit_q       <= '0;
      active_q      <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      nibble_q      <= '0;
      digit_en_q    <= '0;
      frame_tick_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      digit_q       <= digit_d;
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      nibble_q      <= nibble_d;
      digit_en_q    <= digit_en_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  // Disabled scanning freezes state, count and digit; no boundary can occur.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    digit_d  = digit_q;
    boundary = 1'b0;
    if (i_ENABLE) begin
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (digit_q == DIGIT_LAST) begin
              boundary = 1'b1;
              digit_d  = '0;
            end else begin
              digit_d = digit_q + DW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A word accepted on a boundary edge lands in the shadow and waits a full frame.
  always_comb begin
    accept        = i_VALID & ~shadow_full_q;
    active_d      = active_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    if (boundary && shadow_full_q) begin
      active_d      = shadow_q;
      shadow_full_d = 1'b0;
    end else if (accept) begin
      shadow_d      = i_DATA_IN;
      shadow_full_d = 1'b1;
    end

    nibble_sel = '0;
    onehot     = '0;
    lit        = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_d == DW'(k)) begin
        nibble_sel = active_d[4*k +: 4];
        onehot[k]  = 1'b1;
      end
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      if (k > 0) begin
        lit[k] = ((active_d >> (4*k)) != '0);
      end
`endif
    end

    nibble_d = nibble_q;
    if (i_ENABLE && (state_q == ST_SHOW) && (state_d == ST_BLANK)) begin
      nibble_d = nibble_sel;
    end

    digit_en_d = '0;
    if (i_ENABLE && (state_d == ST_SHOW)) begin
      digit_en_d = onehot & lit;
    end

    frame_tick_d = boundary;
  end

  assign o_READY      = ~shadow_full_q;
  assign o_NIBBLE     = nibble_q;
  assign o_DIGIT_EN   = digit_en_q;
  assign o_FRAME_TICK = frame_tick_q;

endmodule
